// File: rtl/apu_pkg.sv
// Shared constants for the multichannel APU: note periods, per-voice
// sequence tables, noise LFSR parameters and a clog2 helper.
package apu_pkg;

  // Tone periods in line ticks (half-period of the square wave minus one).
  localparam logic [8:0] NOTE_E2  = 9'd191;
  localparam logic [8:0] NOTE_FS2 = 9'd170;
  localparam logic [8:0] NOTE_G2  = 9'd161;
  localparam logic [8:0] NOTE_A2  = 9'd143;
  localparam logic [8:0] NOTE_B2  = 9'd127;
  localparam logic [8:0] NOTE_D3  = 9'd107;
  localparam logic [8:0] NOTE_E3  = 9'd95;
  localparam logic [8:0] NOTE_AS4 = 9'd34;
  localparam logic [8:0] NOTE_F5  = 9'd23;
  localparam logic [8:0] NOTE_A5  = 9'd18;
  localparam logic [8:0] REST     = 9'd0;

  localparam int SEQ_VOICES = 4;
  localparam int SEQ_STEPS  = 16;

  // Indexed [voice][step]; a zero entry is a rest.
  localparam logic [8:0] SEQ_TABLE [SEQ_VOICES][SEQ_STEPS] = '{
    '{NOTE_E2, NOTE_E2, NOTE_G2, NOTE_A2, NOTE_B2, REST, NOTE_A2, NOTE_G2,
      NOTE_E2, NOTE_E2, NOTE_D3, NOTE_E3, NOTE_D3, NOTE_B2, NOTE_A2, REST},
    '{NOTE_AS4, NOTE_F5, NOTE_A5, NOTE_F5, NOTE_AS4, REST, NOTE_A5, NOTE_F5,
      NOTE_AS4, NOTE_F5, NOTE_A5, NOTE_F5, REST, NOTE_A5, NOTE_F5, NOTE_AS4},
    '{NOTE_E3, REST, NOTE_E3, REST, NOTE_D3, REST, NOTE_D3, REST,
      NOTE_E3, REST, NOTE_E3, REST, NOTE_B2, REST, NOTE_FS2, REST},
    '{NOTE_A2, NOTE_A2, REST, REST, NOTE_G2, NOTE_G2, REST, REST,
      NOTE_FS2, NOTE_FS2, REST, REST, NOTE_E2, NOTE_E2, REST, REST}
  };

  localparam int             LFSR_W     = 13;
  localparam int             LFSR_TAP_A = 12;
  localparam int             LFSR_TAP_B = 8;
  localparam int             LFSR_TAP_C = 2;
  localparam int             LFSR_TAP_D = 0;
  localparam logic [12:0]    LFSR_SEED  = 13'd0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/apu_tone_voice.sv
// One sequenced square-wave voice: line-tick period divider, square
// flip-flop and a frame-rate decaying envelope reloaded on every step.
module apu_tone_voice
  import apu_pkg::*;
#(
  parameter int DIV_W = 9,
  parameter int ENV_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             line_tick,
  input  logic             frame_tick,
  input  logic             bgm_ena,
  input  logic             step_load,
  input  logic [DIV_W-1:0] period,
  output logic             square,
  output logic [ENV_W-1:0] env
);

  logic [DIV_W-1:0] count;

  // The period is sampled live, so a new step's note takes effect on the
  // next line tick without disturbing the running count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      square <= 1'b0;
    end else if (period == '0) begin
      count  <= '0;
      square <= 1'b0;
    end else if (line_tick) begin
      if (count >= period) begin
        count  <= '0;
        square <= ~square;
      end else begin
        count <= count + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !bgm_ena) begin
      env <= '0;
    end else if (step_load) begin
      env <= '1;
    end else if (frame_tick && env != '0) begin
      env <= env - ENV_W'(1);
    end
  end

endmodule

// File: rtl/apu_multichannel.sv
// Multichannel APU: sequenced tone voices, LFSR noise with a triggered
// SFX envelope, mixed into a first-order sigma-delta audio bitstream.
module apu_multichannel
  import apu_pkg::*;
#(
  parameter int NUM_TONE        = 2,
  parameter int DIV_W           = 9,
  parameter int ENV_W           = 5,
  parameter int SEQ_LEN         = 16,
  parameter int FRAMES_PER_STEP = 16,
  parameter int NOISE_DIV       = 2,
  parameter int SFX_DECAY       = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic line_tick,
  input  logic bgm_ena,
  input  logic sfx_trigger,
  output logic audio_out,
  output logic amp_en,
  output logic seq_wrap,
  output logic sfx_active
);

  localparam int FW = (clog2(FRAMES_PER_STEP) > 0) ? clog2(FRAMES_PER_STEP) : 1;
  localparam int SW = (clog2(SEQ_LEN) > 0) ? clog2(SEQ_LEN) : 1;
  localparam int NW = (clog2(NOISE_DIV) > 0) ? clog2(NOISE_DIV) : 1;
  localparam int MW = ENV_W + clog2(NUM_TONE + 2);

  logic [FW-1:0] frame_cnt;
  logic [SW-1:0] step;
  logic          step_adv;

  assign step_adv = bgm_ena && frame_tick && (frame_cnt == FW'(FRAMES_PER_STEP - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      step      <= '0;
      seq_wrap  <= 1'b0;
      amp_en    <= 1'b0;
    end else begin
      amp_en   <= 1'b1;
      seq_wrap <= step_adv && (step == SW'(SEQ_LEN - 1));
      if (bgm_ena && frame_tick) begin
        if (step_adv) begin
          frame_cnt <= '0;
          step      <= (step == SW'(SEQ_LEN - 1)) ? '0 : step + SW'(1);
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  // Note ROM: sequences longer than the table repeat it.
  function automatic logic [8:0] note_rom(input int voice, input logic [SW-1:0] s);
    logic [3:0] idx;
    logic [8:0] p;
    idx = 4'(s);
    case (voice)
      0:       p = SEQ_TABLE[0][idx];
      1:       p = SEQ_TABLE[1][idx];
      2:       p = SEQ_TABLE[2][idx];
      3:       p = SEQ_TABLE[3][idx];
      default: p = REST;
    endcase
    return p;
  endfunction

  logic [NUM_TONE-1:0] square;
  logic [ENV_W-1:0]    tone_env [NUM_TONE];

  for (genvar k = 0; k < NUM_TONE; k++) begin : g_tone
    logic [DIV_W-1:0] period;
    assign period = DIV_W'(note_rom(k, step));
    apu_tone_voice #(.DIV_W(DIV_W), .ENV_W(ENV_W)) u_voice (
      .clk        (clk),
      .rst_n      (rst_n),
      .line_tick  (line_tick),
      .frame_tick (frame_tick),
      .bgm_ena    (bgm_ena),
      .step_load  (step_adv),
      .period     (period),
      .square     (square[k]),
      .env        (tone_env[k])
    );
  end

  // XNOR feedback keeps the all-zero reset state on a live sequence.
  logic [LFSR_W-1:0] lfsr;
  logic [NW-1:0]     noise_cnt;
  logic              noise;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr      <= LFSR_SEED;
      noise_cnt <= '0;
      noise     <= 1'b0;
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0],
               ~(lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B] ^ lfsr[LFSR_TAP_C] ^ lfsr[LFSR_TAP_D])};
      if (line_tick) begin
        if (noise_cnt == NW'(NOISE_DIV - 1)) begin
          noise_cnt <= '0;
          noise     <= noise ^ (^lfsr);
        end else begin
          noise_cnt <= noise_cnt + NW'(1);
        end
      end
    end
  end

  logic [ENV_W-1:0] sfx_env, sfx_env_nxt;

  always_comb begin
    sfx_env_nxt = sfx_env;
    if (sfx_trigger) begin
      sfx_env_nxt = '1;
    end else if (frame_tick) begin
      sfx_env_nxt = (sfx_env >= ENV_W'(SFX_DECAY)) ? sfx_env - ENV_W'(SFX_DECAY) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sfx_env    <= '0;
      sfx_active <= 1'b0;
    end else begin
      sfx_env    <= sfx_env_nxt;
      sfx_active <= (sfx_env_nxt != '0);
    end
  end

  logic [MW-1:0] mix;
  logic [MW-1:0] acc;
  logic [MW:0]   sd_sum;

  always_comb begin
    mix = noise ? MW'(sfx_env) : '0;
    for (int k = 0; k < NUM_TONE; k++) begin
      if (square[k]) mix = mix + MW'(tone_env[k]);
    end
    sd_sum = {1'b0, acc} + {1'b0, mix};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      audio_out <= 1'b0;
    end else begin
      acc       <= sd_sum[MW-1:0];
      audio_out <= sd_sum[MW];
    end
  end

endmodule

// File: tb/tb_apu_multichannel.sv
// Self-checking bench for apu_multichannel: reset, tone divider, sequencer
// wrap, SFX envelope table, sigma-delta density and mid-note reset.
module tb_apu_multichannel;

  localparam int NOISE_DIV = 2;
  localparam int W         = 8;

  logic clk = 1'b0;
  logic rst_n, frame_tick, line_tick, bgm_ena, sfx_trigger;
  logic audio_out, amp_en, seq_wrap, sfx_active;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  typedef struct packed {
    logic       trig;
    logic       frame;
    logic       active;
    logic [4:0] env;
  } vec_t;
  vec_t vec_tab[$];
  logic [4:0] model_env;

  apu_multichannel #(
    .NUM_TONE(2), .DIV_W(9), .ENV_W(5), .SEQ_LEN(16),
    .FRAMES_PER_STEP(16), .NOISE_DIV(NOISE_DIV), .SFX_DECAY(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .line_tick   (line_tick),
    .bgm_ena     (bgm_ena),
    .sfx_trigger (sfx_trigger),
    .audio_out   (audio_out),
    .amp_en      (amp_en),
    .seq_wrap    (seq_wrap),
    .sfx_active  (sfx_active)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

  // Reference model of the noise voice, used to steer the density tests.
  logic [12:0] m_lfsr;
  logic        m_noise;
  int          m_ncnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_lfsr  <= '0;
      m_noise <= 1'b0;
      m_ncnt  <= 0;
    end else begin
      m_lfsr <= {m_lfsr[11:0], ~(m_lfsr[12] ^ m_lfsr[8] ^ m_lfsr[2] ^ m_lfsr[0])};
      if (line_tick) begin
        if (m_ncnt == NOISE_DIV - 1) begin
          m_ncnt  <= 0;
          m_noise <= m_noise ^ (^m_lfsr);
        end else begin
          m_ncnt <= m_ncnt + 1;
        end
      end
    end
  end

  int wrap_cnt = 0;
  int tone_ones = 0;
  always @(negedge clk) begin
    if (seq_wrap === 1'b1) wrap_cnt++;
    if (audio_out === 1'b1) tone_ones++;
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_line();
    @(negedge clk); line_tick = 1'b1;
    @(negedge clk); line_tick = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic pulse_trig();
    @(negedge clk); sfx_trigger = 1'b1;
    @(negedge clk); sfx_trigger = 1'b0;
  endtask

  task automatic add_vec(input logic trig, input logic frame);
    vec_t v;
    if (trig) model_env = 5'd31;
    else if (frame) model_env = (model_env >= 5'd2) ? model_env - 5'd2 : 5'd0;
    v.trig   = trig;
    v.frame  = frame;
    v.env    = model_env;
    v.active = (model_env != 5'd0);
    vec_tab.push_back(v);
  endtask

  // Steer the noise bit to the wanted value with line ticks (bounded).
  task automatic seek_noise(input logic want, input string name);
    logic found;
    found = 1'b0;
    for (int a = 0; a < 64 && !found; a++) begin
      if (m_noise === want) found = 1'b1;
      else pulse_line();
    end
    check(name, found, 1'b1);
  endtask

  task automatic density(input logic want, input int exp_ones, input string name);
    int ones;
    pulse_trig();
    seek_noise(want, {name, "_seek"});
    exp_q.push_back(W'(exp_ones));
    idle(4);
    ones = 0;
    repeat (128) begin
      @(negedge clk);
      if (audio_out === 1'b1) ones++;
    end
    check(name, ones, exp_q.pop_front());
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int wrap_at;
    int ones;
    logic [W-1:0] act;

    rst_n = 1'b0; frame_tick = 1'b0; line_tick = 1'b0;
    bgm_ena = 1'b0; sfx_trigger = 1'b0;
    idle(4);
    check("rst_audio_out", audio_out, 1'b0);
    check("rst_amp_en", amp_en, 1'b0);
    check("rst_seq_wrap", seq_wrap, 1'b0);
    check("rst_sfx_active", sfx_active, 1'b0);

    rst_n = 1'b1;
    @(negedge clk);
    check("amp_en_after_release", amp_en, 1'b1);
    wrap_cnt = 0; tone_ones = 0;
    idle(100);
    check("idle_audio_ones", tone_ones, 0);
    check("idle_seq_wrap", wrap_cnt, 0);
    check("idle_amp_en", amp_en, 1'b1);

    // Voice 0, step 0: period 191 -> square toggles every 192 line ticks.
    bgm_ena = 1'b1;
    tone_ones = 0;
    for (int n = 1; n <= 400; n++) begin
      pulse_line();
      if (n == 1 || n == 191 || n == 192 || n == 383 || n == 384 || n == 400)
        check($sformatf("square0_tick%0d", n), dut.g_tone[0].u_voice.square, (n / 192) % 2);
      idle(8);
    end
    check("tone_silent_before_step", tone_ones, 0);

    // 256 frames: one wrap, on the last frame, step back at 0.
    wrap_cnt = 0; wrap_at = -1;
    for (int i = 1; i <= 256; i++) begin
      pulse_frame();
      if (seq_wrap === 1'b1) wrap_at = i;
      if (i == 16)  check("step_after_16", dut.step, 1);
      if (i == 255) check("step_after_255", dut.step, 15);
    end
    idle(2);
    check("seq_wrap_count", wrap_cnt, 1);
    check("seq_wrap_frame", wrap_at, 256);
    check("step_after_wrap", dut.step, 0);

    // SFX envelope table, with the sequencer idle.
    bgm_ena = 1'b0;
    idle(2);
    model_env = 5'd0;
    add_vec(1'b1, 1'b0);
    repeat (8) add_vec(1'b0, 1'b1);
    add_vec(1'b1, 1'b0);
    add_vec(1'b1, 1'b1);
    repeat (17) add_vec(1'b0, 1'b1);
    add_vec(1'b0, 1'b0);
    for (int i = 0; i < vec_tab.size(); i++) begin
      @(negedge clk);
      sfx_trigger = vec_tab[i].trig;
      frame_tick  = vec_tab[i].frame;
      exp_q.push_back(W'({vec_tab[i].active, vec_tab[i].env}));
      @(negedge clk);
      sfx_trigger = 1'b0;
      frame_tick  = 1'b0;
      act = W'({sfx_active, dut.sfx_env});
      check($sformatf("sfx_vec%0d", i), act, exp_q.pop_front());
    end

    // Constant mix: noise=1 and sfx_env=31 -> 31 ones per 128 clocks.
    density(1'b1, 31, "density_mix31");
    density(1'b0, 0, "density_mix0");

    // Reset mid-note with the tone and SFX voices sounding.
    bgm_ena = 1'b1;
    repeat (20) pulse_frame();
    check("tone_env0_pre_reset", dut.g_tone[0].u_voice.env, 27);
    pulse_trig();
    seek_noise(1'b1, "pre_reset_seek");
    ones = 0;
    repeat (32) begin
      @(negedge clk);
      if (audio_out === 1'b1) ones++;
    end
    check("pre_reset_audio_active", ones > 0, 1'b1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check("midrst_audio_out", audio_out, 1'b0);
    check("midrst_step", dut.step, 0);
    check("midrst_lfsr", dut.lfsr, 0);
    check("midrst_sfx_active", sfx_active, 1'b0);
    check("midrst_tone_env0", dut.g_tone[0].u_voice.env, 0);
    rst_n = 1'b1;
    idle(2);
    repeat (15) pulse_frame();
    check("restart_step_15f", dut.step, 0);
    pulse_frame();
    check("restart_step_16f", dut.step, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apu_multichannel.md
Name: apu_multichannel

Overview:
- Parametrised successor to the single-voice game APU: NUM_TONE sequenced square-wave voices, one LFSR noise voice and a retriggerable sound-effect envelope.
- Mixes all voices into a 1-bit first-order sigma-delta stream for the uio audio pin.
- Timebase is frame_tick/line_tick pulses from the sync generator, not raw pixel coordinates.
- Sits beside the PPU in the top level; collision pulses drive sfx_trigger.

Parameters:
- NUM_TONE, 2: number of square-wave voices (1..4).
- DIV_W, 9: width of tone period divider, in line ticks.
- ENV_W, 5: envelope amplitude width; max = 2^ENV_W-1.
- SEQ_LEN, 16: sequencer steps per loop (power of 2).
- FRAMES_PER_STEP, 16: frame ticks per sequencer step.
- NOISE_DIV, 2: line ticks between noise-bit updates.
- SFX_DECAY, 2: envelope decrement per frame for the SFX voice.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- line_tick  in  1  one-cycle pulse per scanline
- bgm_ena  in  1  1 = music sequencer runs
- sfx_trigger  in  1  one-cycle pulse that starts the noise SFX
- audio_out  out  1  registered sigma-delta bitstream
- amp_en  out  1  amplifier enable
- seq_wrap  out  1  one-cycle pulse when the step wraps SEQ_LEN-1 -> 0
- sfx_active  out  1  high while the SFX envelope is nonzero

Behaviour:
- Reset (synchronous, rst_n=0 at posedge clk) clears step, frame-in-step counter, all dividers, square states, envelopes, sigma-delta accumulator and LFSR (XNOR form, so all-zero is legal).
- Reset values of outputs: audio_out=0, amp_en=0, seq_wrap=0, sfx_active=0.
- amp_en goes to 1 on the first cycle after reset is released.
- Sequencer advances only while bgm_ena=1. On frame_tick, frame counter increments. At FRAMES_PER_STEP-1 it clears and step increments. step wraps SEQ_LEN-1 -> 0 and seq_wrap pulses for exactly 1 cycle.
- While bgm_ena=0: step and frame counter are held, tone envelopes are forced to 0, and the SFX voice still operates.
- Each tone voice k reads period P = note_rom(k, step), DIV_W bits.
  - On line_tick: if counter >= P, counter <= 0 and square toggles; else counter increments.
  - P=0 is a rest: square held 0, counter held 0.
  - A new step loads the new P on the next line_tick; the counter is not cleared.
- Tone envelope: on step change, env <= max. Then on each frame_tick, env decrements by 1, saturating at 0.
- Noise voice:
  - LFSR (13 bits) shifts every clk; feedback = XNOR of bits 12,8,2,0.
  - Every NOISE_DIV line ticks, noise <= noise ^ (^lfsr).
- SFX:
  - sfx_trigger loads sfx_env <= max; retrigger while active reloads to max.
  - Each frame_tick, sfx_env decrements by SFX_DECAY, saturating at 0.
  - If trigger and frame_tick coincide, the trigger wins.
  - sfx_active = (sfx_env != 0), registered.
- Mixer, evaluated every clk:
  - mix = sum over k of (square_k ? env_k : 0) + (noise ? sfx_env : 0).
  - Width MW = ENV_W + clog2(NUM_TONE+2); no overflow is possible.
- Sigma-delta: acc is MW bits; {carry,acc} <= acc + mix; audio_out <= carry.
  - Output density = mix / 2^MW.
  - mix=0 gives a constant 0.
- Simultaneous frame_tick and line_tick in the same cycle: both are processed independently.
- Asserting reset mid-note immediately silences the output: audio_out is 0 from the cycle after the reset edge.

Decomposition:
- apu_pkg holds:
  - note period constants (E2=191, Fs2=170, G2=161, A2=143, B2=127, D3=107, E3=95, As4=34, F5=23, A5=18);
  - per-voice sequence tables, indexed [voice][step];
  - LFSR width, taps and seed;
  - clog2 function.
- One sub-module, apu_tone_voice: divider, square flip-flop and envelope. It is instantiated NUM_TONE times via generate.
- Note ROM is combinational case logic inside the top module, driven from apu_pkg.

Test Plan:
- Release reset, all ticks low for 100 cycles -> audio_out=0 throughout, amp_en=1 from the cycle after release, seq_wrap never pulses.
- bgm_ena=1; voice0 step0 period 191; line_tick every 10 cycles -> square0 toggles every 192 line ticks (1920 cycles) for the full step.
- bgm_ena=1, FRAMES_PER_STEP=16, SEQ_LEN=16; apply 256 frame_ticks -> seq_wrap pulses exactly once, on the 256th, and step returns to 0.
- Single sfx_trigger, ENV_W=5 -> sfx_active high for 16 frame_ticks (31 -> 1 by 2, then 0); retrigger at frame 8 -> env back to 31 and active for 16 more frames.
- Force mix to a constant by holding bgm_ena=0 with sfx_env=31 and noise=1 (MW=7) -> 31 ones per 128 clk cycles on audio_out.
- Assert rst_n=0 mid-step with env nonzero -> next cycle audio_out=0, step=0, LFSR=0; after release the sequence restarts at step 0.
